// File: rtl/spi_fsm.sv
// Control FSM for the SPI memory peripheral: sequences address latch, shift-register
// parallel load, MISO buffer and data-memory write from chip-select and serial-clock edges.
module spi_fsm #(
  parameter int WIDTH  = 8,
  parameter int COUNTW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sClkEdge,
  input  logic              chipSelect,
  input  logic              readWriteBit,
  output logic              addrLatchEnable,
  output logic              srParallelLoad,
  output logic              misoBufferEnable,
  output logic              dmWriteEnable,
  output logic              busy,
  output logic [2:0]        stateOut,
  output logic [COUNTW-1:0] bitCount
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_SHIFT = 3'd5,
    WRITE_MEM   = 3'd6,
    DONE        = 3'd7
  } state_t;

  localparam logic [COUNTW-1:0] LAST = COUNTW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [COUNTW-1:0] cnt_q, cnt_d;
  logic              ale_q, srl_q, miso_q, dmwe_q, busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // CS deassertion wins over any edge or pending strobe
    if (state_q != IDLE && chipSelect) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (!chipSelect) begin
          state_d = GET_ADDR;
          cnt_d   = '0;
        end
        GET_ADDR: if (sClkEdge) begin
          if (cnt_q == LAST) begin
            state_d = GOT_ADDR;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        GOT_ADDR:  state_d = readWriteBit ? READ_LOAD : WRITE_SHIFT;
        READ_LOAD: state_d = READ_SHIFT;
        READ_SHIFT: if (sClkEdge) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        WRITE_SHIFT: if (sClkEdge) begin
          if (cnt_q == LAST) begin
            state_d = WRITE_MEM;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        WRITE_MEM: state_d = DONE;
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ale_q   <= 1'b0;
      srl_q   <= 1'b0;
      miso_q  <= 1'b0;
      dmwe_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ale_q   <= (state_d == GOT_ADDR);
      srl_q   <= (state_d == READ_LOAD);
      miso_q  <= (state_d == READ_SHIFT);
      dmwe_q  <= (state_d == WRITE_MEM);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign addrLatchEnable  = ale_q;
  assign srParallelLoad   = srl_q;
  assign misoBufferEnable = miso_q;
  assign dmWriteEnable    = dmwe_q;
  assign busy             = busy_q;
  assign stateOut         = state_q;
  assign bitCount         = cnt_q;

endmodule

// File: tb/tb_spi_fsm.sv
// Bench for spi_fsm: transaction-level model (edge counts + cycles since frame end)
// compared every cycle, plus directed literal checks of timing and strobe counts.
module tb_spi_fsm;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, sClkEdge, chipSelect, readWriteBit;
  logic          addrLatchEnable, srParallelLoad, misoBufferEnable, dmWriteEnable, busy;
  logic [2:0]    stateOut;
  logic [CW-1:0] bitCount;

  spi_fsm #(.WIDTH(W), .COUNTW(CW)) dut (
    .clk(clk), .reset(reset), .sClkEdge(sClkEdge), .chipSelect(chipSelect),
    .readWriteBit(readWriteBit), .addrLatchEnable(addrLatchEnable),
    .srParallelLoad(srParallelLoad), .misoBufferEnable(misoBufferEnable),
    .dmWriteEnable(dmWriteEnable), .busy(busy), .stateOut(stateOut), .bitCount(bitCount)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: act = transaction open, n = counted edges (0..2W), since = cycles since
  // the edge that finished a frame, rw = direction captured right after the address.
  bit act = 0, rw = 0;
  int n = 0, since = 0;

  always @(posedge clk) begin
    if (reset) begin act = 0; n = 0; since = 0; end
    else if (!act) begin if (!chipSelect) begin act = 1; n = 0; since = 0; end end
    else if (chipSelect) begin act = 0; n = 0; since = 0; end
    else if (n < W) begin if (sClkEdge) begin n++; since = 0; end end
    else if (n == W && since == 0) begin rw = readWriteBit; since = 1; end
    else if (n == W && rw && since == 1) since = 2;
    else if (n < 2*W) begin if (sClkEdge) begin n++; since = 0; end end
    else if (!rw && since == 0) since = 1;
  end

  function automatic int exp_state();
    if (!act) return 0;
    if (n < W) return 1;
    if (n == W && since == 0) return 2;
    if (n < 2*W) return rw ? ((n == W && since == 1) ? 3 : 4) : 5;
    return (!rw && since == 0) ? 6 : 7;
  endfunction

  int ale_cnt = 0, srl_cnt = 0, miso_cnt = 0, dmwe_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int es;
      es = exp_state();
      chk("stateOut", stateOut, es);
      chk("bitCount", bitCount, n % W);
      chk("busy", busy, act);
      chk("addrLatchEnable", addrLatchEnable, es == 2);
      chk("srParallelLoad", srParallelLoad, es == 3);
      chk("misoBufferEnable", misoBufferEnable, es == 4);
      chk("dmWriteEnable", dmWriteEnable, es == 6);
      ale_cnt  += addrLatchEnable;
      srl_cnt  += srParallelLoad;
      miso_cnt += misoBufferEnable;
      dmwe_cnt += dmWriteEnable;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic edge_pulse();
    sClkEdge = 1'b1; tick(1);
    sClkEdge = 1'b0; tick(3);
  endtask

  int a0, s0, m0, d0;

  initial begin
    reset = 1'b1; chipSelect = 1'b0; sClkEdge = 1'b1; readWriteBit = 1'b0;
    tick(1);
    chk_en = 1'b1;
    sClkEdge = 1'b0; tick(1);
    chk("rst_state", stateOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", bitCount, 0);
    reset = 1'b0; chipSelect = 1'b1; tick(2);

    // read transaction
    a0 = ale_cnt; s0 = srl_cnt; m0 = miso_cnt;
    readWriteBit = 1'b1; chipSelect = 1'b0; tick(1);
    chk("rd_getaddr", stateOut, 1);
    repeat (W-1) edge_pulse();
    chk("rd_cnt7", bitCount, 7);
    sClkEdge = 1'b1; tick(1); sClkEdge = 1'b0;
    chk("rd_ale_N+1", addrLatchEnable, 1);
    tick(1);
    chk("rd_srl_N+2", srParallelLoad, 1);
    tick(1);
    chk("rd_miso_on", misoBufferEnable, 1);
    repeat (W-1) edge_pulse();
    sClkEdge = 1'b1; tick(1); sClkEdge = 1'b0;
    chk("rd_done", stateOut, 7);
    chk("rd_miso_off", misoBufferEnable, 0);
    tick(2);
    chk("rd_ale_once", ale_cnt - a0, 1);
    chk("rd_srl_once", srl_cnt - s0, 1);
    chk("rd_miso_cycles", miso_cnt - m0, 29);
    chipSelect = 1'b1; tick(1);
    chk("rd_idle", stateOut, 0);
    tick(2);

    // write transaction
    m0 = miso_cnt; d0 = dmwe_cnt;
    readWriteBit = 1'b0; chipSelect = 1'b0; tick(1);
    repeat (2*W-1) edge_pulse();
    chk("wr_shift", stateOut, 5);
    sClkEdge = 1'b1; tick(1); sClkEdge = 1'b0;
    chk("wr_dmwe", dmWriteEnable, 1);
    tick(1);
    chk("wr_done", stateOut, 7);
    chk("wr_dmwe_off", dmWriteEnable, 0);

    // overrun in DONE
    a0 = ale_cnt; s0 = srl_cnt;
    repeat (4) edge_pulse();
    chk("ovr_state", stateOut, 7);
    chk("ovr_cnt", bitCount, 0);
    chk("ovr_strobes", (ale_cnt - a0) + (srl_cnt - s0), 0);
    chk("wr_dmwe_once", dmwe_cnt - d0, 1);
    chk("wr_no_miso", miso_cnt - m0, 0);
    chipSelect = 1'b1; tick(2);

    // abort after edge 12 of a write
    d0 = dmwe_cnt;
    chipSelect = 1'b0; tick(1);
    repeat (12) edge_pulse();
    chk("ab_cnt4", bitCount, 4);
    chipSelect = 1'b1; tick(1);
    chk("ab_idle", stateOut, 0);
    chk("ab_cnt0", bitCount, 0);
    tick(4);
    chk("ab_no_dmwe", dmwe_cnt - d0, 0);

    // CS rise coincident with 8th address edge
    a0 = ale_cnt;
    chipSelect = 1'b0; tick(1);
    repeat (W-1) edge_pulse();
    sClkEdge = 1'b1; chipSelect = 1'b1; tick(1); sClkEdge = 1'b0;
    chk("sim_idle", stateOut, 0);
    tick(3);
    chk("sim_no_ale", ale_cnt - a0, 0);

    // CS rise coincident with last write data edge: no write
    d0 = dmwe_cnt;
    chipSelect = 1'b0; tick(1);
    repeat (2*W-1) edge_pulse();
    sClkEdge = 1'b1; chipSelect = 1'b1; tick(1); sClkEdge = 1'b0;
    chk("sim2_idle", stateOut, 0);
    tick(3);
    chk("sim2_no_dmwe", dmwe_cnt - d0, 0);

    // reset mid-transaction
    chipSelect = 1'b0; tick(1);
    repeat (3) edge_pulse();
    reset = 1'b1; tick(1); reset = 1'b0; chipSelect = 1'b1;
    chk("mid_rst_state", stateOut, 0);
    chk("mid_rst_cnt", bitCount, 0);
    tick(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
